// File: rtl/store_queue_pkg.sv
// Shared sizing constants and types for the LSU store queue.
package store_queue_pkg;

    localparam int SQ_NUM   = 4;
    localparam int SQ_WIDTH = $clog2(SQ_NUM);
    localparam int XLEN     = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_t;

    typedef struct packed {
        logic            valid;
        logic            ready;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        mem_size_t       size;
    } sq_entry_t;

endpackage

// File: rtl/store_queue_byte_mask.sv
// Byte-enable generator: access size and low address bits to a 4-bit lane mask.
module sq_byte_mask
    import store_queue_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] mask
);

    always_comb begin
        mask = 4'b0000;
        case (size)
            SIZE_BYTE: mask = 4'b0001 << addr_lo;
            SIZE_HALF: mask = 4'b0011 << addr_lo;
            SIZE_WORD: mask = 4'b1111;
            default:   mask = 4'b0000;
        endcase
    end

endmodule

// File: rtl/store_queue.sv
// Circular store queue: holds stores from dispatch to commit, drains committed
// stores in order to the dcache, and serves load-forwarding lookups.
module store_queue
    import store_queue_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                alloc_valid,
    output logic                alloc_ready,
    output logic [SQ_WIDTH-1:0] alloc_index,
    input  logic                exe_valid,
    input  logic [SQ_WIDTH-1:0] exe_index,
    input  logic [XLEN-1:0]     exe_addr,
    input  logic [XLEN-1:0]     exe_data,
    input  logic [1:0]          exe_size,
    input  logic                commit_valid,
    input  logic                flush,
    input  logic                ld_valid,
    input  logic [XLEN-1:0]     ld_addr,
    input  logic [1:0]          ld_size,
    input  logic [SQ_WIDTH-1:0] ld_sq_tail,
    output logic [SQ_NUM-1:0]   match,
    output logic [SQ_WIDTH-1:0] push_head,
    input  logic                fwd_hit,
    input  logic [SQ_WIDTH-1:0] fwd_index,
    output logic [XLEN-1:0]     fwd_data,
    output logic                ld_stall,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [XLEN-1:0]     mem_req_addr,
    output logic [XLEN-1:0]     mem_req_data,
    output logic [1:0]          mem_req_size
);

    localparam int CNT_W = SQ_WIDTH + 1;

    sq_entry_t [SQ_NUM-1:0] entries;
    logic [SQ_WIDTH-1:0]    head;
    logic [SQ_WIDTH-1:0]    tail;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       ccnt;

    logic                   alloc_fire;
    logic                   exe_fire;
    logic                   commit_fire;
    logic                   drain_fire;
    logic [SQ_WIDTH-1:0]    commit_idx;
    logic [SQ_WIDTH-1:0]    head_n;
    logic [SQ_WIDTH-1:0]    tail_n;
    logic [CNT_W-1:0]       count_n;
    logic [CNT_W-1:0]       ccnt_n;

    logic [3:0]             smask [SQ_NUM];
    logic [3:0]             lmask;
    logic [SQ_WIDTH-1:0]    keep_off [SQ_NUM];
    logic [SQ_WIDTH-1:0]    age_off [SQ_NUM];
    logic [SQ_WIDTH-1:0]    ld_span;
    logic [SQ_NUM-1:0]      keep;
    logic [SQ_NUM-1:0]      older;
    logic [SQ_NUM-1:0]      unresolved;
    logic                   fwd_partial;
    logic [XLEN-1:0]        fwd_shift;

    // Expand a byte-enable mask into a bit mask over the data word.
    function automatic logic [XLEN-1:0] lane_bits(input logic [3:0] be);
        logic [XLEN-1:0] bits;
        bits = '0;
        for (int b = 0; b < 4; b++) bits[8*b +: 8] = {8{be[b]}};
        return bits;
    endfunction

    assign alloc_ready = (count != CNT_W'(SQ_NUM));
    assign alloc_index = tail;
    assign alloc_fire  = alloc_valid & alloc_ready & ~flush;
    assign exe_fire    = exe_valid & ~flush & entries[exe_index].valid;
    assign commit_idx  = head + ccnt[SQ_WIDTH-1:0];
    assign commit_fire = commit_valid & (ccnt != count);

    assign mem_req_valid = (ccnt != '0) & entries[head].valid;
    assign mem_req_addr  = entries[head].addr;
    assign mem_req_data  = entries[head].data;
    assign mem_req_size  = entries[head].size;
    assign drain_fire    = mem_req_valid & mem_req_ready;

    // Flush rebuilds tail from the post-drain head so only committed stores survive.
    always_comb begin
        head_n = head + SQ_WIDTH'(drain_fire);
        ccnt_n = ccnt + CNT_W'(commit_fire) - CNT_W'(drain_fire);
        if (flush) begin
            count_n = ccnt_n;
            tail_n  = head_n + ccnt_n[SQ_WIDTH-1:0];
        end else begin
            count_n = count + CNT_W'(alloc_fire) - CNT_W'(drain_fire);
            tail_n  = tail + SQ_WIDTH'(alloc_fire);
        end
    end

    sq_byte_mask u_lmask (
        .size    (ld_size),
        .addr_lo (ld_addr[1:0]),
        .mask    (lmask)
    );

    assign push_head = ld_sq_tail;
    assign ld_span   = ld_sq_tail - head;

    for (genvar i = 0; i < SQ_NUM; i++) begin : g_entry
        sq_byte_mask u_smask (
            .size    (entries[i].size),
            .addr_lo (entries[i].addr[1:0]),
            .mask    (smask[i])
        );
        assign keep_off[i]   = SQ_WIDTH'(i) - head_n;
        assign keep[i]       = {1'b0, keep_off[i]} < ccnt_n;
        assign age_off[i]    = SQ_WIDTH'(i) - head;
        assign older[i]      = entries[i].valid & (age_off[i] < ld_span);
        assign unresolved[i] = older[i] & ~entries[i].ready;
        assign match[i]      = ld_valid & older[i] & entries[i].ready
                             & (entries[i].addr[XLEN-1:2] == ld_addr[XLEN-1:2])
                             & (|(smask[i] & lmask));
    end

    // Store data goes to its own memory lane, then only the load's bytes are kept.
    assign fwd_shift   = entries[fwd_index].data << {entries[fwd_index].addr[1:0], 3'b000};
    assign fwd_data    = fwd_hit ? (fwd_shift & lane_bits(lmask)) : '0;
    assign fwd_partial = (smask[fwd_index] & lmask) != lmask;
    assign ld_stall    = ld_valid & ((|unresolved) | (fwd_hit & fwd_partial));

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ccnt  <= '0;
            for (int i = 0; i < SQ_NUM; i++) begin
                entries[i].valid <= 1'b0;
                entries[i].ready <= 1'b0;
            end
        end else begin
            head  <= head_n;
            tail  <= tail_n;
            count <= count_n;
            ccnt  <= ccnt_n;
            for (int i = 0; i < SQ_NUM; i++) begin
                if (flush && !keep[i]) begin
                    entries[i].valid <= 1'b0;
                    entries[i].ready <= 1'b0;
                end
            end
            if (drain_fire) begin
                entries[head].valid <= 1'b0;
                entries[head].ready <= 1'b0;
            end
            if (alloc_fire) begin
                entries[tail].valid <= 1'b1;
                entries[tail].ready <= 1'b0;
            end
            if (exe_fire) begin
                entries[exe_index].ready <= 1'b1;
                entries[exe_index].addr  <= exe_addr;
                entries[exe_index].data  <= exe_data;
                entries[exe_index].size  <= mem_size_t'(exe_size);
            end
        end
    end

    a_exe_to_valid: assert property (@(posedge clk) disable iff (reset)
        (exe_valid && !flush) |-> entries[exe_index].valid)
        else $error("store_queue: exe to unallocated entry");

    a_commit_legal: assert property (@(posedge clk) disable iff (reset)
        commit_valid |-> ((ccnt != count) && entries[commit_idx].ready))
        else $error("store_queue: commit with no resolved uncommitted store");

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue with an age-ordered reference queue model.
module tb_store_queue;
    import store_queue_pkg::*;

    logic                clk;
    logic                reset;
    logic                alloc_valid;
    logic                alloc_ready;
    logic [SQ_WIDTH-1:0] alloc_index;
    logic                exe_valid;
    logic [SQ_WIDTH-1:0] exe_index;
    logic [XLEN-1:0]     exe_addr;
    logic [XLEN-1:0]     exe_data;
    logic [1:0]          exe_size;
    logic                commit_valid;
    logic                flush;
    logic                ld_valid;
    logic [XLEN-1:0]     ld_addr;
    logic [1:0]          ld_size;
    logic [SQ_WIDTH-1:0] ld_sq_tail;
    logic [SQ_NUM-1:0]   match;
    logic [SQ_WIDTH-1:0] push_head;
    logic                fwd_hit;
    logic [SQ_WIDTH-1:0] fwd_index;
    logic [XLEN-1:0]     fwd_data;
    logic                ld_stall;
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [XLEN-1:0]     mem_req_addr;
    logic [XLEN-1:0]     mem_req_data;
    logic [1:0]          mem_req_size;

    store_queue dut (
        .clk           (clk),
        .reset         (reset),
        .alloc_valid   (alloc_valid),
        .alloc_ready   (alloc_ready),
        .alloc_index   (alloc_index),
        .exe_valid     (exe_valid),
        .exe_index     (exe_index),
        .exe_addr      (exe_addr),
        .exe_data      (exe_data),
        .exe_size      (exe_size),
        .commit_valid  (commit_valid),
        .flush         (flush),
        .ld_valid      (ld_valid),
        .ld_addr       (ld_addr),
        .ld_size       (ld_size),
        .ld_sq_tail    (ld_sq_tail),
        .match         (match),
        .push_head     (push_head),
        .fwd_hit       (fwd_hit),
        .fwd_index     (fwd_index),
        .fwd_data      (fwd_data),
        .ld_stall      (ld_stall),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_req_size  (mem_req_size)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, req, $time);
        end
    endtask

    // Reference model: stores in age order, q[0] is the oldest (head) entry.
    typedef struct {
        logic        ready;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } mrec_t;

    mrec_t q[$];
    int    m_head = 0;
    int    m_ccnt = 0;
    bit    live = 0;

    function automatic logic [3:0] ref_mask(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] m;
        int len;
        m = '0;
        len = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        for (int b = 0; b < 4; b++)
            m[b] = (sz == 2'd2) || (b >= int'(off) && b < int'(off) + len);
        return m;
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [31:0] d, input logic [1:0] soff,
                                             input logic [3:0] lm);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++)
            if (lm[b] && b >= int'(soff)) r[8*b +: 8] = d[8*(b - int'(soff)) +: 8];
        return r;
    endfunction

    task automatic model_step();
        int k;
        bit full, drain, commit;
        mrec_t rec;
        if (reset) begin
            q.delete();
            m_head = 0;
            m_ccnt = 0;
            live = 1;
            return;
        end
        if (!live) return;
        full   = (q.size() == SQ_NUM);
        drain  = (m_ccnt > 0) && mem_req_ready;
        commit = commit_valid && (m_ccnt < q.size());
        if (!flush) begin
            if (exe_valid) begin
                k = (int'(exe_index) - m_head + SQ_NUM) % SQ_NUM;
                if (k < q.size()) begin
                    q[k].ready = 1'b1;
                    q[k].addr  = exe_addr;
                    q[k].data  = exe_data;
                    q[k].size  = exe_size;
                end
            end
            if (alloc_valid && !full) begin
                rec.ready = 1'b0;
                rec.addr  = '0;
                rec.data  = '0;
                rec.size  = '0;
                q.push_back(rec);
            end
        end
        if (commit) m_ccnt++;
        if (drain) begin
            void'(q.pop_front());
            m_head = (m_head + 1) % SQ_NUM;
            m_ccnt--;
        end
        if (flush)
            while (q.size() > m_ccnt) void'(q.pop_back());
    endtask

    task automatic compare();
        logic [3:0]  em;
        logic [3:0]  lm;
        logic [3:0]  sm;
        logic        es;
        logic        fwd_known;
        logic [31:0] ef;
        int n, span, k, slot;
        n = q.size();
        chk("alloc_ready", alloc_ready, n != SQ_NUM);
        chk("alloc_index", alloc_index, (m_head + n) % SQ_NUM);
        chk("mem_req_valid", mem_req_valid, m_ccnt > 0);
        if (m_ccnt > 0) begin
            chk("mem_req_addr", mem_req_addr, q[0].addr);
            chk("mem_req_data", mem_req_data, q[0].data);
            chk("mem_req_size", mem_req_size, q[0].size);
        end
        chk("push_head", push_head, ld_sq_tail);
        em = '0;
        es = 1'b0;
        lm = ref_mask(ld_size, ld_addr[1:0]);
        span = (int'(ld_sq_tail) - m_head + SQ_NUM) % SQ_NUM;
        for (k = 0; k < span && k < n; k++) begin
            slot = (m_head + k) % SQ_NUM;
            if (ld_valid) begin
                if (!q[k].ready) es = 1'b1;
                else if (q[k].addr[31:2] == ld_addr[31:2] &&
                         (ref_mask(q[k].size, q[k].addr[1:0]) & lm) != 4'b0000)
                    em[slot] = 1'b1;
            end
        end
        fwd_known = 1'b1;
        ef = '0;
        if (fwd_hit) begin
            k = (int'(fwd_index) - m_head + SQ_NUM) % SQ_NUM;
            if (k < n && q[k].ready) begin
                sm = ref_mask(q[k].size, q[k].addr[1:0]);
                ef = ref_fwd(q[k].data, q[k].addr[1:0], lm);
                if (ld_valid && (sm & lm) != lm) es = 1'b1;
            end else begin
                fwd_known = 1'b0;
            end
        end
        chk("match", match, em);
        if (fwd_known) begin
            chk("ld_stall", ld_stall, es);
            chk("fwd_data", fwd_data, ef);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (live) compare();
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid   = 1'b0;
        exe_valid     = 1'b0;
        commit_valid  = 1'b0;
        flush         = 1'b0;
        ld_valid      = 1'b0;
        fwd_hit       = 1'b0;
        mem_req_ready = 1'b0;
    endtask

    task automatic do_exe(input logic [1:0] idx, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] sz);
        exe_valid = 1'b1;
        exe_index = idx;
        exe_addr  = a;
        exe_data  = d;
        exe_size  = sz;
        step();
        exe_valid = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        exe_index = '0; exe_addr = '0; exe_data = '0; exe_size = '0;
        ld_addr = '0; ld_size = '0; ld_sq_tail = '0; fwd_index = '0;

        @(negedge clk);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_match", match, 0);
        chk("rst_ld_stall", ld_stall, 0);
        chk("rst_fwd_data", fwd_data, 0);
        step();
        reset = 1'b0;

        // Fill the queue, then try one more allocation.
        for (int k = 0; k < 4; k++) begin
            alloc_valid = 1'b1;
            @(negedge clk);
            chk("fill_alloc_index", alloc_index, k);
            step();
        end
        @(negedge clk);
        chk("full_alloc_ready", alloc_ready, 0);
        step();
        alloc_valid = 1'b0;
        @(negedge clk);
        chk("full_count", dut.count, 4);
        chk("full_alloc_ready2", alloc_ready, 0);

        // Commit entry 0 and hold the dcache off for three cycles.
        step();
        do_exe(2'd0, 32'h100, 32'hAABBCCDD, 2'd2);
        commit_valid = 1'b1;
        step();
        commit_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_valid", mem_req_valid, 1);
            chk("hold_addr", mem_req_addr, 32'h100);
            chk("hold_data", mem_req_data, 32'hAABBCCDD);
            step();
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        @(negedge clk);
        chk("drain_head", dut.head, 1);
        chk("drain_count", dut.count, 3);
        chk("drain_alloc_ready", alloc_ready, 1);

        // Partial and full coverage forwarding.
        step();
        do_exe(2'd1, 32'h200, 32'h11111111, 2'd2);
        do_exe(2'd2, 32'h201, 32'h00000022, 2'd0);
        ld_valid = 1'b1; ld_addr = 32'h200; ld_size = 2'd2; ld_sq_tail = 2'd3;
        fwd_hit = 1'b1; fwd_index = 2'd2;
        @(negedge clk);
        chk("part_match", match, 4'b0110);
        chk("part_push_head", push_head, 3);
        chk("part_stall", ld_stall, 1);
        step();
        ld_addr = 32'h201; ld_size = 2'd0;
        @(negedge clk);
        chk("full_cov_stall", ld_stall, 0);
        chk("full_cov_data", fwd_data, 32'h00002200);
        step();

        // Older unresolved store (entry 3) blocks any load past it.
        ld_addr = 32'h300; ld_size = 2'd2; ld_sq_tail = 2'd0; fwd_hit = 1'b0;
        @(negedge clk);
        chk("unres_stall", ld_stall, 1);
        chk("unres_match", match, 4'b0000);
        step();
        idle();

        // Retire entries 1 and 2, then flush the unresolved entry 3.
        commit_valid = 1'b1;
        step();
        step();
        commit_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        step();
        mem_req_ready = 1'b0;
        @(negedge clk);
        chk("pre_flush_head", dut.head, 3);
        chk("pre_flush_count", dut.count, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_count", dut.count, 0);
        chk("flush_tail", dut.tail, 3);

        // Wrapped fill 3,0,1,2; commit two; flush with a same-cycle drain.
        alloc_valid = 1'b1;
        repeat (4) step();
        alloc_valid = 1'b0;
        do_exe(2'd3, 32'h500, 32'h33333333, 2'd2);
        do_exe(2'd0, 32'h600, 32'h44444444, 2'd2);
        do_exe(2'd1, 32'h700, 32'h00005566, 2'd1);
        do_exe(2'd2, 32'h702, 32'h00007788, 2'd1);
        commit_valid = 1'b1;
        step();
        step();
        commit_valid = 1'b0;
        flush = 1'b1; mem_req_ready = 1'b1; alloc_valid = 1'b1;
        step();
        idle();
        @(negedge clk);
        chk("fd_head", dut.head, 0);
        chk("fd_ccnt", dut.ccnt, 1);
        chk("fd_count", dut.count, 1);
        chk("fd_tail", dut.tail, 1);
        chk("fd_alloc_index", alloc_index, 1);
        chk("fd_mem_addr", mem_req_addr, 32'h600);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        @(negedge clk);
        chk("empty_count", dut.count, 0);
        chk("empty_mem_valid", mem_req_valid, 0);

        // Unresolved older entry 1 with a resolved byte store in entry 2.
        alloc_valid = 1'b1;
        step();
        step();
        alloc_valid = 1'b0;
        do_exe(2'd2, 32'h404, 32'h00000055, 2'd0);
        ld_valid = 1'b1; ld_addr = 32'h404; ld_size = 2'd2; ld_sq_tail = 2'd3;
        @(negedge clk);
        chk("old_unres_stall", ld_stall, 1);
        chk("old_unres_match", match, 4'b0100);
        step();
        ld_size = 2'd0; fwd_hit = 1'b1; fwd_index = 2'd2;
        @(negedge clk);
        chk("old_unres_fwd", fwd_data, 32'h00000055);
        chk("old_unres_stall2", ld_stall, 1);
        step();
        idle();

        // Reset in the middle of operation wins over a concurrent alloc.
        reset = 1'b1; alloc_valid = 1'b1;
        step();
        reset = 1'b0; alloc_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_count", dut.count, 0);
        chk("mid_rst_alloc_index", alloc_index, 0);
        chk("mid_rst_mem_valid", mem_req_valid, 0);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
